// File: rtl/mem_pkg.sv
// Shared widths, command record and FSM state type for the RAM request master.
package mem_pkg;

    localparam int W      = 8;
    localparam int addr_w = 4;

    typedef struct packed {
        logic              wrd;
        logic [addr_w-1:0] addr;
        logic [W-1:0]      wdata;
    } mem_cmd_t;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } mreq_st_e;

endpackage

// File: rtl/mem_cmd_fifo.sv
// Synchronous command FIFO with a combinational head; a pop consumes the entry
// presented on pop_data_o in the same cycle.
module mem_cmd_fifo
    import mem_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  mem_cmd_t      push_data_i,
    input  logic          pop_i,
    output mem_cmd_t      pop_data_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [PW:0]   count_o
);

    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW:0]   count_q;
    mem_cmd_t      mem_q [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count_q == (PW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign pop_data_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/mem_req_master.sv
// Issues buffered read/write commands one at a time on the RAM valid/ready port,
// returns read data on a one-cycle strobe and drops requests that stall too long.
module mem_req_master
    import mem_pkg::*;
#(
    parameter int CMD_DEPTH = 4,
    parameter int TIMEOUT   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_wrd,
    input  logic [addr_w-1:0] cmd_addr,
    input  logic [W-1:0]      cmd_wdata,
    output logic              mem_valid,
    output logic              mem_wrd,
    output logic [addr_w-1:0] mem_addr,
    output logic [W-1:0]      mem_wdata,
    input  logic              mem_ready,
    input  logic [W-1:0]      mem_rdata,
    output logic              rsp_valid,
    output logic [addr_w-1:0] rsp_addr,
    output logic [W-1:0]      rsp_rdata,
    output logic              busy,
    output logic              err
);

    localparam int CPW    = $clog2(CMD_DEPTH);
    localparam int WAIT_W = $clog2(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    mreq_st_e          state_q, state_d;
    mem_cmd_t          cmd_q, cmd_d;
    logic              valid_q, valid_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [addr_w-1:0] rsp_addr_q, rsp_addr_d;
    logic [W-1:0]      rsp_rdata_q, rsp_rdata_d;
    logic              err_q, err_d;

    mem_cmd_t          push_cmd;
    mem_cmd_t          head_cmd;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CPW:0]      fifo_count;

    assign push_cmd = '{wrd: cmd_wrd, addr: cmd_addr, wdata: cmd_wdata};

    mem_cmd_fifo #(.DEPTH(CMD_DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (cmd_valid),
        .push_data_i (push_cmd),
        .pop_i       (fifo_pop),
        .pop_data_o  (head_cmd),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        valid_d     = valid_q;
        wait_d      = wait_q;
        rsp_valid_d = 1'b0;
        rsp_addr_d  = rsp_addr_q;
        rsp_rdata_d = rsp_rdata_q;
        err_d       = 1'b0;
        fifo_pop    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    cmd_d    = head_cmd;
                    valid_d  = 1'b1;
                    wait_d   = '0;
                    state_d  = REQ;
                end
            end
            REQ: begin
                // A ready on the last wait cycle still counts as a completion.
                if (mem_ready || (wait_q == WAIT_LAST)) begin
                    if (mem_ready && !cmd_q.wrd) begin
                        rsp_valid_d = 1'b1;
                        rsp_addr_d  = cmd_q.addr;
                        rsp_rdata_d = mem_rdata;
                    end
                    err_d  = ~mem_ready;
                    wait_d = '0;
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        cmd_d    = head_cmd;
                    end else begin
                        valid_d = 1'b0;
                        state_d = IDLE;
                    end
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cmd_q       <= '0;
            valid_q     <= 1'b0;
            wait_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_addr_q  <= '0;
            rsp_rdata_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            valid_q     <= valid_d;
            wait_q      <= wait_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_addr_q  <= rsp_addr_d;
            rsp_rdata_q <= rsp_rdata_d;
            err_q       <= err_d;
        end
    end

    assign cmd_ready = ~fifo_full;
    assign mem_valid = valid_q;
    assign mem_wrd   = cmd_q.wrd;
    assign mem_addr  = cmd_q.addr;
    assign mem_wdata = cmd_q.wdata;
    assign rsp_valid = rsp_valid_q;
    assign rsp_addr  = rsp_addr_q;
    assign rsp_rdata = rsp_rdata_q;
    assign busy      = (fifo_count != '0) | valid_q;
    assign err       = err_q;

endmodule
